res_drain_buf: RTL and testbench
================================

# res_drain_buf

Result drain buffer for the matrix-multiply systolic array. It accepts packed words of IN result elements from the array edge in one beat and presents them downstream one WIDTH element per cycle, in a fixed order. It is the wide-in / narrow-out counterpart of the scratchpad buffer, which loads elements one at a time and reads them out as packed words. Flow control is a valid/ready handshake on both sides.

## Interface
- DEPTH, default 8: storage in elements. Must be a power of two, with DEPTH >= IN.
- WIDTH, default 16: element width in bits.
- IN, default 2: elements per input beat.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous clear of all buffered data.
- in_valid  in  1  the upstream word in_data is valid.
- in_data  in  WIDTH*IN  packed elements. Lane 0, the first element out, is in_data[WIDTH*IN-1 -: WIDTH]. Lane IN-1 is in the LSBs.
- in_ready  out  1  the buffer can accept a full IN-element beat.
- out_valid  out  1  out_data holds a valid element.
- out_data  out  WIDTH  the oldest buffered element.
- out_ready  in  1  downstream consumes out_data.
- count  out  $clog2(DEPTH)+1  number of buffered elements, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- Storage is an element array mem[0:DEPTH-1]. It is not reset.
- Pointers:
  - w_ptr and r_ptr are each $clog2(DEPTH)+1 bits.
  - The low bits index mem. The MSB is the wrap bit.
  - Both increment modulo 2*DEPTH.
  - count = w_ptr - r_ptr, evaluated modulo 2*DEPTH.
- Push fires when in_valid && in_ready.
  - Lane k is written to mem[(w_ptr+k) mod DEPTH], for k = 0..IN-1.
  - w_ptr advances by IN.
  - A partial beat is never accepted.
- in_ready = (DEPTH - count) >= IN.
  - It is computed only from registered count.
  - A same-cycle pop does not raise in_ready; there is no bypass.
- Pop fires when out_valid && out_ready. r_ptr advances by 1.
- out_valid = !empty.
- out_data = mem[r_ptr low bits] when out_valid is 1, and 0 when out_valid is 0. This is a first-word-fall-through read.
- Simultaneous push and pop in one cycle:
  - Both take effect.
  - count changes by IN-1.
  - The pop reads the old head, never the element being written that cycle.
- Wrap-around:
  - A beat may straddle the end of mem. Index arithmetic is modulo DEPTH.
  - Element order is preserved across the wrap.
- flush = 1:
  - The next edge sets w_ptr = r_ptr = 0.
  - Any push or pop in that cycle is ignored.
  - flush has priority over both handshakes.
- Handshake rules:
  - Upstream holds in_data stable while in_valid && !in_ready.
  - Asserting out_ready while out_valid = 0 has no effect.
- Push and pop are the only state-changing events. There is no other FSM.
- The 2-bit mode {push, pop} fully determines the next pointer state.

## Timing
- Reset (rst_n = 0), asynchronous:
  - w_ptr = r_ptr = 0, so count = 0, empty = 1 and full = 0.
  - out_valid = 0 and out_data = 0.
  - in_ready = 1.
  - Outputs take these values immediately, without waiting for clk.
- Reset asserted mid-operation discards all data. The first push after deassertion is accepted on the first rising edge where in_valid = 1.
- Push-to-output latency is 1 cycle. For a beat accepted at edge N, lane 0 appears on out_data with out_valid = 1 after edge N.
- Throughput:
  - Output: one element per cycle.
  - Input: one beat per cycle while space >= IN.
- Sustained streaming with IN > 1 and out_ready = 1 fills the buffer. in_ready then throttles input to 1 beat per IN cycles.
- count, full, empty, in_ready and out_valid all update on the same edge as the pointers. None has a combinational path from in_valid or out_ready.

## Test plan
Parameters for all scenarios: DEPTH = 8, WIDTH = 16, IN = 2.
- **Reset values:** hold rst_n = 0 -> out_valid = 0, out_data = 0, in_ready = 1, count = 0, empty = 1, full = 0.
- **Ordering:** push 0xAAAA_BBBB with out_ready = 1 -> next cycle out_data = 0xAAAA; the following cycle out_data = 0xBBBB; then empty = 1 and out_valid = 0.
- **Full boundary:**
  - With out_ready = 0, push 4 beats -> count = 8, full = 1, in_ready = 0; a 5th in_valid is held and not accepted.
  - Pop 1 -> count = 7, in_ready = 0.
  - Pop 1 more -> count = 6, in_ready = 1.
- **Simultaneous push and pop** at count = 3 -> count = 4, and the popped element is the old head.
- **Wrap-around:** stream 20 beats holding values 0x0000..0x0027 with random out_ready -> 40 elements come out in exact ascending order, with no loss or duplication and with pointers wrapping at least twice.
- **Flush and async reset:**
  - Assert flush at count = 5, together with in_valid and out_ready -> next cycle count = 0, empty = 1, and no push is stored.
  - Drop rst_n asynchronously mid-stream -> outputs take their reset values before the next clk edge.

Source files
------------

// File: rtl/res_drain_buf.sv
// Wide-in / narrow-out drain buffer: accepts IN packed result elements per beat
// and streams them out one element per cycle in lane order (lane 0 first).
module res_drain_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int IN    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH*IN-1:0]      in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] STEP_IN  = PW'(IN);
  localparam logic [PW-1:0] FILL_LIM = PW'(DEPTH - IN);
  localparam logic [PW-1:0] CAP      = PW'(DEPTH);

  logic [PW-1:0]    w_ptr_q, w_ptr_d;
  logic [PW-1:0]    r_ptr_q, r_ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push;
  logic             pop;

  // Status is derived purely from the registered pointers, so no output
  // depends combinationally on in_valid or out_ready.
  assign count     = w_ptr_q - r_ptr_q;
  assign full      = (count == CAP);
  assign empty     = (count == '0);
  assign in_ready  = (count <= FILL_LIM);
  assign out_valid = !empty;
  assign out_data  = out_valid ? mem[r_ptr_q[AW-1:0]] : '0;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    if (flush) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
    end else begin
      case ({push, pop})
        2'b10: w_ptr_d = w_ptr_q + STEP_IN;
        2'b01: r_ptr_d = r_ptr_q + PW'(1);
        2'b11: begin
          w_ptr_d = w_ptr_q + STEP_IN;
          r_ptr_d = r_ptr_q + PW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
    end
  end

  // Storage carries no reset; lane k lands at w_ptr+k, wrapping modulo DEPTH.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < IN; k++) begin
        mem[AW'(w_ptr_q[AW-1:0] + AW'(k))] <= in_data[WIDTH*(IN-k)-1 -: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_res_drain_buf.sv
// Directed bench for res_drain_buf with a queue scoreboard of expected elements.
module tb_res_drain_buf;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;
  localparam int IN    = 2;

  logic                   clk;
  logic                   rst_n;
  logic                   flush;
  logic                   in_valid;
  logic [WIDTH*IN-1:0]    in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic                   out_ready;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;

  res_drain_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH), .IN(IN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb_q [$];
  int  cnt       = 0;
  int  popped    = 0;
  bit  last_push = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs settled: verify outputs against the
  // model, then advance one rising edge and update the model.
  task automatic tick();
    bit exp_rdy, exp_vld, pf, pp;
    logic [WIDTH*IN-1:0] word;
    logic [WIDTH-1:0]    head;
    exp_rdy = (DEPTH - cnt) >= IN;
    exp_vld = (cnt != 0);
    head    = '0;
    if (exp_vld && sb_q.size() > 0) head = sb_q[0];
    chk("count", 32'(count), 32'(cnt));
    chk("full", 32'(full), 32'(cnt == DEPTH));
    chk("empty", 32'(empty), 32'(cnt == 0));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(exp_vld));
    chk("out_data", 32'(out_data), 32'(head));
    pf   = in_valid && exp_rdy && !flush;
    pp   = out_ready && exp_vld && !flush;
    word = in_data;
    @(posedge clk);
    last_push = pf;
    if (flush) begin
      sb_q.delete();
      cnt = 0;
    end else begin
      if (pp) begin
        void'(sb_q.pop_front());
        cnt--;
        popped++;
      end
      if (pf) begin
        for (int k = 0; k < IN; k++) sb_q.push_back(word[WIDTH*(IN-k)-1 -: WIDTH]);
        cnt += IN;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && cnt != 0; c++) tick();
    chk("drain_done", 32'(cnt), 32'd0);
  endtask

  initial begin
    int beat;
    int p0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ordering: lane 0 first
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hAAAA_BBBB;
    tick();
    in_valid = 1'b0;
    chk("ord_lane0", 32'(out_data), 32'h0000_AAAA);
    tick();
    chk("ord_lane1", 32'(out_data), 32'h0000_BBBB);
    tick();
    chk("ord_empty", 32'(empty), 32'd1);
    chk("ord_out_valid", 32'(out_valid), 32'd0);

    // Full boundary
    out_ready = 1'b0; in_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      in_data = {16'(16'h1000 + 2*b), 16'(16'h1001 + 2*b)};
      tick();
    end
    in_data = 32'hDEAD_BEEF;
    tick();
    chk("full_count", 32'(count), 32'd8);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("pop1_count", 32'(count), 32'd7);
    chk("pop1_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    chk("pop2_count", 32'(count), 32'd6);
    chk("pop2_in_ready", 32'(in_ready), 32'd1);
    drain();

    // Simultaneous push and pop at count 3
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h2000_2001; tick();
    in_data = 32'h2002_2003; tick();
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("sim_pre_count", 32'(count), 32'd3);
    in_valid = 1'b1; in_data = 32'h2004_2005;
    chk("sim_head", 32'(out_data), 32'h0000_2001);
    tick();
    chk("sim_count", 32'(count), 32'd4);
    chk("sim_new_head", 32'(out_data), 32'h0000_2002);
    drain();

    // Wrap-around streaming with random backpressure
    beat = 0;
    p0   = popped;
    for (int c = 0; c < 600 && (beat < 20 || cnt != 0); c++) begin
      in_valid  = (beat < 20);
      in_data   = {16'(2*beat), 16'(2*beat + 1)};
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (last_push) beat++;
    end
    chk("wrap_beats", 32'(beat), 32'd20);
    chk("wrap_popped", 32'(popped - p0), 32'd40);
    chk("wrap_left", 32'(cnt), 32'd0);

    // Flush at count 5 with both handshakes active
    out_ready = 1'b0; in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      in_data = {16'(16'h3000 + 2*b), 16'(16'h3001 + 2*b)};
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("fl_pre_count", 32'(count), 32'd5);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h4444_5555;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    tick();

    // Asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h5000_5001; tick();
    in_data = 32'h5002_5003; tick();
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_empty", 32'(empty), 32'd1);
    sb_q.delete();
    cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'h0000_1234);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
